// File: rtl/br_commit_queue.sv
// In-order branch commit queue: fetch allocates, execute resolves by tag out of order,
// commit retires the head and emits BTB training plus a misprediction redirect.
module br_commit_queue #(
    parameter int ADDR  = 32,
    parameter int DEPTH = 8,
    parameter int TAG   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            alloc_,
    input  logic [ADDR-1:0] alloc_pc,
    input  logic            alloc_pred_taken,
    input  logic [ADDR-1:0] alloc_pred_tar,
    output logic [TAG-1:0]  alloc_tag,
    output logic            queue_full,
    output logic            queue_empty,
    input  logic            resolve_,
    input  logic [TAG-1:0]  resolve_tag,
    input  logic            resolve_taken,
    input  logic [ADDR-1:0] resolve_tar,
    input  logic            commit_,
    output logic            commit_ready,
    input  logic            flush_,
    output logic            pc_chg_com_,
    output logic            chg_taken_,
    output logic [ADDR-1:0] com_addr,
    output logic [ADDR-1:0] com_tar_addr,
    output logic            mispred_,
    output logic [ADDR-1:0] redirect_addr
);

    localparam logic [TAG:0]    C_FULL    = (TAG+1)'(DEPTH);
    localparam logic [TAG:0]    C_CNT_ONE = (TAG+1)'(1);
    localparam logic [TAG-1:0]  C_TAG_ONE = TAG'(1);
    localparam logic [ADDR-1:0] C_FOUR    = ADDR'(4);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_resolved;
    logic [ADDR-1:0]  r_pc        [DEPTH];
    logic             r_pred_taken[DEPTH];
    logic [ADDR-1:0]  r_pred_tar  [DEPTH];
    logic             r_act_taken [DEPTH];
    logic [ADDR-1:0]  r_act_tar   [DEPTH];

    logic [TAG-1:0]   r_head;
    logic [TAG-1:0]   r_tail;
    logic [TAG:0]     r_count;

    logic             r_pc_chg_com_;
    logic             r_chg_taken_;
    logic [ADDR-1:0]  r_com_addr;
    logic [ADDR-1:0]  r_com_tar_addr;
    logic             r_mispred_;
    logic [ADDR-1:0]  r_redirect_addr;

    logic             w_flush;
    logic             w_alloc;
    logic             w_resolve;
    logic             w_commit;
    logic             w_mispred;
    logic             w_clear;
    logic [ADDR-1:0]  w_redirect;

    // Handshakes: an active-low request is taken on the edge where it is sampled low
    // and its ready condition (not full / head resolved) holds from pre-edge state.
    assign alloc_tag    = r_tail;
    assign queue_full   = (r_count == C_FULL);
    assign queue_empty  = (r_count == '0);
    assign commit_ready = r_valid[r_head] & r_resolved[r_head];

    assign w_flush    = ~flush_;
    assign w_alloc    = ~alloc_ & ~queue_full;
    assign w_resolve  = ~resolve_ & r_valid[resolve_tag];
    assign w_commit   = ~commit_ & commit_ready & ~w_flush;
    assign w_mispred  = (r_pred_taken[r_head] != r_act_taken[r_head]) |
                        (r_act_taken[r_head] & (r_pred_tar[r_head] != r_act_tar[r_head]));
    assign w_clear    = w_flush | (w_commit & w_mispred);
    assign w_redirect = r_act_taken[r_head] ? r_act_tar[r_head] : (r_pc[r_head] + C_FOUR);

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_valid         <= '0;
            r_resolved      <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_pc_chg_com_   <= 1'b1;
            r_chg_taken_    <= 1'b1;
            r_mispred_      <= 1'b1;
            r_com_addr      <= '0;
            r_com_tar_addr  <= '0;
            r_redirect_addr <= '0;
        end else begin
            r_pc_chg_com_ <= 1'b1;
            r_chg_taken_  <= 1'b1;
            r_mispred_    <= 1'b1;
            if (w_commit) begin
                r_pc_chg_com_  <= 1'b0;
                r_chg_taken_   <= ~r_act_taken[r_head];
                r_com_addr     <= r_pc[r_head];
                r_com_tar_addr <= r_act_tar[r_head];
                if (w_mispred) begin
                    r_mispred_      <= 1'b0;
                    r_redirect_addr <= w_redirect;
                end
            end
            if (w_clear) begin
                // Flush or redirect: every in-flight entry is on the wrong path.
                r_valid    <= '0;
                r_resolved <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_resolve) begin
                    r_resolved[resolve_tag] <= 1'b1;
                end
                if (w_alloc) begin
                    r_valid[r_tail]    <= 1'b1;
                    r_resolved[r_tail] <= 1'b0;
                    r_tail             <= r_tail + C_TAG_ONE;
                end
                if (w_commit) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + C_TAG_ONE;
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + C_CNT_ONE;
                    2'b01:   r_count <= r_count - C_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset; it is only read behind the valid/resolved bits.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_pc[r_tail]         <= alloc_pc;
            r_pred_taken[r_tail] <= alloc_pred_taken;
            r_pred_tar[r_tail]   <= alloc_pred_tar;
        end
        if (w_resolve) begin
            r_act_taken[resolve_tag] <= resolve_taken;
            r_act_tar[resolve_tag]   <= resolve_tar;
        end
    end

    assign pc_chg_com_   = r_pc_chg_com_;
    assign chg_taken_    = r_chg_taken_;
    assign com_addr      = r_com_addr;
    assign com_tar_addr  = r_com_tar_addr;
    assign mispred_      = r_mispred_;
    assign redirect_addr = r_redirect_addr;

endmodule

// File: tb/tb_br_commit_queue.sv
// Directed bench for br_commit_queue: queue-level reference model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_br_commit_queue;

    localparam int DEPTH = 8;
    localparam int TAG   = 3;

    typedef struct {
        logic [TAG-1:0] tag;
        logic [31:0]    pc;
        logic           pt;
        logic [31:0]    ptar;
        logic           res;
        logic           at;
        logic [31:0]    atar;
    } ent_t;

    logic           clk;
    logic           reset_;
    logic           alloc_;
    logic [31:0]    alloc_pc;
    logic           alloc_pred_taken;
    logic [31:0]    alloc_pred_tar;
    logic [TAG-1:0] alloc_tag;
    logic           queue_full;
    logic           queue_empty;
    logic           resolve_;
    logic [TAG-1:0] resolve_tag;
    logic           resolve_taken;
    logic [31:0]    resolve_tar;
    logic           commit_;
    logic           commit_ready;
    logic           flush_;
    logic           pc_chg_com_;
    logic           chg_taken_;
    logic [31:0]    com_addr;
    logic [31:0]    com_tar_addr;
    logic           mispred_;
    logic [31:0]    redirect_addr;

    br_commit_queue #(.ADDR(32), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_           (reset_),
        .alloc_           (alloc_),
        .alloc_pc         (alloc_pc),
        .alloc_pred_taken (alloc_pred_taken),
        .alloc_pred_tar   (alloc_pred_tar),
        .alloc_tag        (alloc_tag),
        .queue_full       (queue_full),
        .queue_empty      (queue_empty),
        .resolve_         (resolve_),
        .resolve_tag      (resolve_tag),
        .resolve_taken    (resolve_taken),
        .resolve_tar      (resolve_tar),
        .commit_          (commit_),
        .commit_ready     (commit_ready),
        .flush_           (flush_),
        .pc_chg_com_      (pc_chg_com_),
        .chg_taken_       (chg_taken_),
        .com_addr         (com_addr),
        .com_tar_addr     (com_tar_addr),
        .mispred_         (mispred_),
        .redirect_addr    (redirect_addr)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    logic chk_en = 1'b0;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic chk_t(input string nm, input logic [TAG-1:0] act, input logic [TAG-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // reference model: entries in program order, updated at each active edge
    ent_t           exp_q[$];
    int             m_tail = 0;
    logic           e_pcc = 1'b1, e_mis = 1'b1, e_chg = 1'b1;
    logic [31:0]    e_caddr = '0, e_ctar = '0, e_redir = '0;
    logic           m_full, m_ready, m_com, m_bad;
    ent_t           h, n, r;

    always @(posedge clk) begin
        m_full  = (exp_q.size() == DEPTH);
        m_ready = (exp_q.size() > 0) && exp_q[0].res;
        e_pcc   = 1'b1;
        e_mis   = 1'b1;
        if (!reset_) begin
            exp_q.delete();
            m_tail  = 0;
            e_chg   = 1'b1;
            e_caddr = '0;
            e_ctar  = '0;
            e_redir = '0;
        end else if (!flush_) begin
            exp_q.delete();
            m_tail = 0;
        end else begin
            m_com = !commit_ && m_ready;
            m_bad = 1'b0;
            if (m_com) begin
                h       = exp_q[0];
                e_pcc   = 1'b0;
                e_chg   = !h.at;
                e_caddr = h.pc;
                e_ctar  = h.atar;
                m_bad   = (h.pt != h.at) || (h.at && (h.ptar != h.atar));
                if (m_bad) begin
                    e_mis   = 1'b0;
                    e_redir = h.at ? h.atar : h.pc + 32'd4;
                    exp_q.delete();
                    m_tail = 0;
                end
            end
            if (!m_bad) begin
                if (!resolve_) begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].tag == resolve_tag) begin
                            r      = exp_q[i];
                            r.res  = 1'b1;
                            r.at   = resolve_taken;
                            r.atar = resolve_tar;
                            exp_q[i] = r;
                        end
                    end
                end
                if (m_com) void'(exp_q.pop_front());
                if (!alloc_ && !m_full) begin
                    n.tag  = TAG'(m_tail);
                    n.pc   = alloc_pc;
                    n.pt   = alloc_pred_taken;
                    n.ptar = alloc_pred_tar;
                    n.res  = 1'b0;
                    n.at   = 1'b0;
                    n.atar = '0;
                    exp_q.push_back(n);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk_t("alloc_tag", alloc_tag, TAG'(m_tail));
            chk_b("queue_full", queue_full, exp_q.size() == DEPTH);
            chk_b("queue_empty", queue_empty, exp_q.size() == 0);
            chk_b("commit_ready", commit_ready, (exp_q.size() > 0) && exp_q[0].res);
            chk_b("pc_chg_com_", pc_chg_com_, e_pcc);
            chk_b("mispred_", mispred_, e_mis);
            if (!e_pcc) begin
                chk_b("chg_taken_", chg_taken_, e_chg);
                chk_a("com_addr", com_addr, e_caddr);
                chk_a("com_tar_addr", com_tar_addr, e_ctar);
            end
            if (!e_mis) chk_a("redirect_addr", redirect_addr, e_redir);
        end
    end

    // driver tasks
    task automatic idle();
        alloc_ = 1'b1; alloc_pc = '0; alloc_pred_taken = 1'b0; alloc_pred_tar = '0;
        resolve_ = 1'b1; resolve_tag = '0; resolve_taken = 1'b0; resolve_tar = '0;
        commit_ = 1'b1; flush_ = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] ptar);
        alloc_ = 1'b0; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_tar = ptar;
        cycle();
    endtask

    task automatic do_resolve(input logic [TAG-1:0] tg, input logic tk, input logic [31:0] tar);
        resolve_ = 1'b0; resolve_tag = tg; resolve_taken = tk; resolve_tar = tar;
        cycle();
    endtask

    task automatic do_commit();
        commit_ = 1'b0;
        cycle();
    endtask

    initial begin
        idle();
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        chk_b("rst pc_chg_com_", pc_chg_com_, 1'b1);
        chk_b("rst chg_taken_", chg_taken_, 1'b1);
        chk_b("rst mispred_", mispred_, 1'b1);
        chk_a("rst com_addr", com_addr, 32'h0);
        chk_a("rst com_tar_addr", com_tar_addr, 32'h0);
        chk_a("rst redirect_addr", redirect_addr, 32'h0);
        chk_b("rst queue_full", queue_full, 1'b0);
        chk_b("rst queue_empty", queue_empty, 1'b1);
        chk_b("rst commit_ready", commit_ready, 1'b0);
        chk_t("rst alloc_tag", alloc_tag, 3'd0);
        reset_ = 1'b1;
        chk_en = 1'b1;

        // correctly predicted taken branch
        do_alloc(32'hdeadbe74, 1'b1, 32'hcafecafe);
        chk_b("t1 ready before resolve", commit_ready, 1'b0);
        do_resolve(3'd0, 1'b1, 32'hcafecafe);
        chk_b("t1 ready", commit_ready, 1'b1);
        do_commit();
        chk_b("t1 pc_chg_com_", pc_chg_com_, 1'b0);
        chk_b("t1 chg_taken_", chg_taken_, 1'b0);
        chk_a("t1 com_addr", com_addr, 32'hdeadbe74);
        chk_a("t1 com_tar_addr", com_tar_addr, 32'hcafecafe);
        chk_b("t1 mispred_", mispred_, 1'b1);
        cycle();
        chk_b("t1 pulse ends", pc_chg_com_, 1'b1);

        // direction mispredict with younger entries behind the head (head tag 1)
        do_alloc(32'hdeadbe18, 1'b0, 32'h0);
        do_alloc(32'h00000010, 1'b0, 32'h0);
        do_alloc(32'h00000020, 1'b0, 32'h0);
        do_alloc(32'h00000030, 1'b0, 32'h0);
        do_resolve(3'd1, 1'b1, 32'hfffecafe);
        do_commit();
        chk_b("t2 mispred_", mispred_, 1'b0);
        chk_a("t2 redirect_addr", redirect_addr, 32'hfffecafe);
        chk_b("t2 queue_empty", queue_empty, 1'b1);
        chk_a("t2 com_addr", com_addr, 32'hdeadbe18);
        chk_t("t2 alloc_tag", alloc_tag, 3'd0);

        // predicted taken, actually not taken
        do_alloc(32'h00000100, 1'b1, 32'h00000200);
        do_resolve(3'd0, 1'b0, 32'h00000200);
        do_commit();
        chk_b("t3 chg_taken_", chg_taken_, 1'b1);
        chk_b("t3 mispred_", mispred_, 1'b0);
        chk_a("t3 redirect_addr", redirect_addr, 32'h00000104);

        // fill, overflow, drain three, wrap
        for (int i = 0; i < DEPTH; i++) begin
            chk_t("t4 fill tag", alloc_tag, TAG'(i));
            do_alloc(32'h1000 + 32'(16 * i), 1'b0, 32'h0);
        end
        chk_b("t4 full", queue_full, 1'b1);
        do_alloc(32'h0000bad0, 1'b0, 32'h0);
        chk_b("t4 still full", queue_full, 1'b1);
        chk_t("t4 tag after drop", alloc_tag, 3'd0);
        for (int i = 0; i < DEPTH; i++) do_resolve(TAG'(i), 1'b0, 32'h1008 + 32'(16 * i));
        commit_ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_b("t4 b2b pulse", pc_chg_com_, 1'b0);
            chk_a("t4 b2b com_addr", com_addr, 32'h1000 + 32'(16 * k));
            chk_a("t4 b2b com_tar", com_tar_addr, 32'h1008 + 32'(16 * k));
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            chk_t("t4 wrap tag", alloc_tag, TAG'(i));
            do_alloc(32'h2000 + 32'(16 * i), 1'b0, 32'h0);
        end
        chk_b("t4 full again", queue_full, 1'b1);
        alloc_ = 1'b0; alloc_pc = 32'h0000bad1; commit_ = 1'b0;
        cycle();
        chk_a("t4 commit while full", com_addr, 32'h00001030);
        chk_t("t4 alloc refused", alloc_tag, 3'd3);
        chk_b("t4 not full", queue_full, 1'b0);
        alloc_ = 1'b0; alloc_pc = 32'h00002030; commit_ = 1'b0;
        cycle();
        chk_a("t4 commit+alloc", com_addr, 32'h00001040);
        chk_t("t4 commit+alloc tag", alloc_tag, 3'd4);
        for (int i = 0; i < 4; i++) do_resolve(TAG'(i), 1'b0, 32'h0);
        commit_ = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk_a("t4 drain order", com_addr,
                  (k < 3) ? 32'h1050 + 32'(16 * k) : 32'h2000 + 32'(16 * (k - 3)));
        end
        idle();
        chk_b("t4 drained", queue_empty, 1'b1);

        // flush of a non-empty queue
        do_alloc(32'h00000500, 1'b0, 32'h0);
        do_alloc(32'h00000510, 1'b0, 32'h0);
        flush_ = 1'b0;
        cycle();
        chk_b("t5 flush empty", queue_empty, 1'b1);
        chk_t("t5 flush tag", alloc_tag, 3'd0);

        // out-of-order resolve with commit held, then flush against commit
        do_alloc(32'h00003000, 1'b0, 32'h0);
        do_alloc(32'h00003010, 1'b0, 32'h0);
        commit_ = 1'b0; resolve_ = 1'b0; resolve_tag = 3'd1;
        @(negedge clk);
        chk_b("t6 ready after tag1", commit_ready, 1'b0);
        resolve_tag = 3'd0;
        @(negedge clk);
        chk_b("t6 ready after tag0", commit_ready, 1'b1);
        chk_b("t6 no bypass", pc_chg_com_, 1'b1);
        resolve_ = 1'b1; flush_ = 1'b0;
        cycle();
        chk_b("t6 flush no pulse", pc_chg_com_, 1'b1);
        chk_b("t6 flush no mispred", mispred_, 1'b1);
        chk_b("t6 flush empty", queue_empty, 1'b1);

        // invalid-tag resolve ignored, second resolve overwrites the first
        do_alloc(32'h00004000, 1'b1, 32'h00004400);
        do_resolve(3'd5, 1'b1, 32'h00004400);
        chk_b("t7 invalid resolve", commit_ready, 1'b0);
        do_resolve(3'd0, 1'b0, 32'h0);
        do_resolve(3'd0, 1'b1, 32'h00004400);
        do_commit();
        chk_b("t7 overwrite no mispred", mispred_, 1'b1);
        chk_b("t7 taken", chg_taken_, 1'b0);

        // reset mid-operation
        do_alloc(32'h00005000, 1'b0, 32'h0);
        do_alloc(32'h00005010, 1'b0, 32'h0);
        reset_ = 1'b0; alloc_ = 1'b0; alloc_pc = 32'h00005020;
        cycle();
        reset_ = 1'b1;
        chk_b("t8 reset empty", queue_empty, 1'b1);
        chk_t("t8 reset tag", alloc_tag, 3'd0);
        cycle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/br_commit_queue.md
# br_commit_queue

In-order branch commit queue that produces the BTB training interface and the misprediction redirect. Fetch allocates one entry per predicted branch, execute resolves entries out of order by tag, and commit retires the head in program order. Each retirement emits one training pulse (`pc_chg_com_`, `chg_taken_`, `com_addr`, `com_tar_addr`) toward the BTB. A retirement whose prediction was wrong also emits a redirect and empties the queue.

## Interface
- `ADDR`, 32, address width
- `DEPTH`, 8, number of entries (power of two, >= 2)
- `TAG`, $clog2(DEPTH), tag width
- `clk`  in  1  clock
- `reset_`  in  1  one clock; reset is synchronous and active-low
- `alloc_`  in  1  active-low allocate request
- `alloc_pc`  in  ADDR  branch PC
- `alloc_pred_taken`  in  1  predicted direction
- `alloc_pred_tar`  in  ADDR  predicted target
- `alloc_tag`  out  TAG  tag of the entry being allocated (combinational, equals tail pointer)
- `queue_full`  out  1  high when count == DEPTH
- `queue_empty`  out  1  high when count == 0
- `resolve_`  in  1  active-low resolve strobe
- `resolve_tag`  in  TAG  entry being resolved
- `resolve_taken`  in  1  actual direction
- `resolve_tar`  in  ADDR  actual target
- `commit_`  in  1  active-low retire request for the head entry
- `commit_ready`  out  1  high when the head is valid and resolved
- `flush_`  in  1  active-low external flush
- `pc_chg_com_`  out  1  active-low training pulse, registered
- `chg_taken_`  out  1  active-low "branch taken", valid with `pc_chg_com_`
- `com_addr`  out  ADDR  committed branch PC
- `com_tar_addr`  out  ADDR  actual target
- `mispred_`  out  1  active-low misprediction pulse, registered
- `redirect_addr`  out  ADDR  correct next PC, valid with `mispred_`

## Operation
**Entry state**
- Each entry holds: valid, resolved, pc, pred_taken, pred_tar, act_taken, act_tar.
- Pointers: head, tail (TAG bits, wrap modulo DEPTH) and count (TAG+1 bits).

**Allocate**
- Accepted when `alloc_` is low and `queue_full` is low.
- Writes the tail entry with valid=1 and resolved=0, then advances tail.
- An allocate while full is silently dropped; count and pointers do not change.

**Resolve**
- When `resolve_` is low and the entry at `resolve_tag` is valid, the block stores act_taken and act_tar and sets resolved=1.
- A resolve to an invalid entry is ignored.
- A second resolve to the same entry overwrites the first.

**Commit**
- Accepted when `commit_` is low and `commit_ready` is high.
- The head entry is invalidated and head advances.
- The training outputs are registered from the head entry:
  - `chg_taken_` = !act_taken
  - `com_addr` = pc
  - `com_tar_addr` = act_tar
- A misprediction is defined as (pred_taken != act_taken) or (act_taken and pred_tar != act_tar).
- On a misprediction:
  - `mispred_` pulses low.
  - `redirect_addr` = act_taken ? act_tar : pc + 4.
  - All entries are invalidated: head = tail = 0, count = 0.
- A commit request while `commit_ready` is low is ignored, and no pulse is produced.

**Flush**
- `flush_` low invalidates all entries and sets head = tail = count = 0.
- Flush produces no training pulse and no misprediction pulse.

**Simultaneous events**
- Flush beats commit, allocate and resolve in the same cycle.
- A mispredicted commit beats an allocate in the same cycle; the allocated entry is discarded.
- A correct commit together with an allocate: both take effect and count is unchanged. `queue_full` is computed from the pre-cycle count, so an allocate while full is still refused even with a concurrent commit.
- Resolve of the head in the same cycle as a commit request: no bypass. The commit waits until the next cycle.

## Timing
- Reset values:
  - `pc_chg_com_`, `chg_taken_` and `mispred_` = 1.
  - `com_addr`, `com_tar_addr` and `redirect_addr` = 0.
  - `queue_full` = 0, `queue_empty` = 1, `commit_ready` = 0.
  - All entries invalid.
- Reset applied mid-operation behaves exactly like the reset values above, applied at the next clock edge.
- `alloc_tag`, `queue_full`, `queue_empty` and `commit_ready` are combinational from registered state.
- A resolve at edge N makes `commit_ready` high after edge N, provided the entry is the head.
- A commit sampled at edge N drives `pc_chg_com_` (and `mispred_`, if applicable) low for exactly the cycle after edge N. The pulse returns to 1 at edge N+1 unless another commit occurs.
- Back-to-back commits give one pulse per cycle.
- Pointers wrap from DEPTH-1 to 0 with no bubble.

## Test plan
- **Reset state:** reset held 2 cycles -> all outputs at their reset values; `queue_empty`=1.
- **Correct taken branch:**
  - Stimulus: allocate pc=0xdeadbe74, pred taken, pred target 0xcafecafe; resolve the same target as taken; commit.
  - Required response: one cycle with `pc_chg_com_`=0, `chg_taken_`=0, `com_addr`=0xdeadbe74, `com_tar_addr`=0xcafecafe; `mispred_` stays 1.
- **Direction mispredict:**
  - Stimulus: allocate pc=0xdeadbe18 predicted not-taken, plus 3 younger entries; resolve the head as taken to 0xfffecafe; commit.
  - Required response: `mispred_`=0, `redirect_addr`=0xfffecafe, `queue_empty`=1 on the next cycle.
- **Not-taken mispredict:**
  - Stimulus: pc=0x100 predicted taken to 0x200; resolve as not-taken.
  - Required response: `chg_taken_`=1 and `redirect_addr`=0x104.
- **Full and wrap:**
  - Stimulus: fill 8 entries, then allocate a 9th; commit 3 and allocate 3 more.
  - Required response: `queue_full`=1 and the 9th entry is dropped; tags wrap as 0,1,2 and commits emerge in allocation order.
- **Out-of-order resolve and flush priority:**
  - Stimulus: resolve tag 1 before tag 0; hold `commit_` low throughout; then assert `flush_` together with `commit_`.
  - Required response: `commit_ready` stays 0 until tag 0 is resolved; the flush cycle produces no pulse and leaves the queue empty.
